load_store_unit: RTL and testbench

Memory-access stage of the RV64 core. It sits between execute and writeback, and between the core and the data memory. It takes one memory operation from execute over a valid/ready handshake and runs it on a request/grant/response data-memory bus. It then returns the aligned, sign- or zero-extended result to writeback, replacing the fixed one-cycle memory access with a multi-cycle, stall-capable one.

---
 rtl/load_store_unit.sv | 154 +++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage between execute and writeback.
// Accepts one operation at a time and runs it on a request/grant/response
// data-memory bus. Loads return lane-extracted, sign/zero-extended data.
// Non-memory ops and faulting accesses complete without touching the bus.
module load_store_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] ex_addr,
   input  logic [XLEN-1:0] ex_wdata,
   input  logic [2:0]      ex_funct3,
   input  logic            ex_mem_read,
   input  logic            ex_mem_write,
   input  logic            ex_reg_write,
   input  logic [4:0]      ex_rd,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_be,
   input  logic            dmem_gnt,
   input  logic            dmem_rvalid,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            wb_valid,
   output logic            wb_reg_write,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            mem_fault
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   // Operation captured at accept; the bus fields are derived from it.
   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [2:0]      funct3;
      logic            store;
      logic            reg_write;
      logic [4:0]      rd;
   } op_t;

   state_t          state, state_nx;
   op_t             op_q;
   logic [XLEN-1:0] wdata_q;
   logic [7:0]      be_q;
   logic            accept, is_mem, misaligned, illegal, fault;
   logic [7:0]      size_mask;
   logic [XLEN-1:0] ld_shift, ld_val;

   assign ex_ready   = (state == IDLE) && reset;
   assign dmem_req   = (state == REQ);
   assign dmem_we    = op_q.store;
   assign dmem_addr  = {op_q.addr[XLEN-1:3], 3'b000};
   assign dmem_wdata = wdata_q;
   assign dmem_be    = be_q;

   // Decode the incoming op: access size, alignment and legality.
   always_comb begin
      accept     = ex_valid && ex_ready;
      is_mem     = ex_mem_read || ex_mem_write;
      misaligned = 1'b0;
      size_mask  = 8'h01;
      case (ex_funct3[1:0])
         2'd0: begin misaligned = 1'b0;            size_mask = 8'h01; end
         2'd1: begin misaligned = ex_addr[0];      size_mask = 8'h03; end
         2'd2: begin misaligned = |ex_addr[1:0];   size_mask = 8'h0F; end
         default: begin misaligned = |ex_addr[2:0]; size_mask = 8'hFF; end
      endcase
      illegal = (ex_mem_read && ex_mem_write) ||
                (ex_mem_read && (ex_funct3 == 3'b111)) ||
                (ex_mem_write && ex_funct3[2]);
      fault   = is_mem && (illegal || misaligned);
   end

   // Pull the addressed bytes down to lane 0 and extend per funct3.
   always_comb begin
      ld_shift = dmem_rdata >> {op_q.addr[2:0], 3'b000};
      case (op_q.funct3)
         3'b000:  ld_val = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
         3'b001:  ld_val = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
         3'b010:  ld_val = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
         3'b100:  ld_val = {{(XLEN-8){1'b0}},  ld_shift[7:0]};
         3'b101:  ld_val = {{(XLEN-16){1'b0}}, ld_shift[15:0]};
         3'b110:  ld_val = {{(XLEN-32){1'b0}}, ld_shift[31:0]};
         default: ld_val = ld_shift;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: faults and non-memory ops skip the bus entirely.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = (is_mem && !fault) ? REQ : DONE;
         REQ:  if (dmem_gnt) state_nx = op_q.store ? DONE : WAIT;
         WAIT: if (dmem_rvalid) state_nx = DONE;
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Capture registers and registered writeback outputs; wb_* only change
   // on the edge that enters DONE so they hold between results.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op_q         <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         wb_valid     <= 1'b0;
         wb_reg_write <= 1'b0;
         wb_rd        <= '0;
         wb_data      <= '0;
         mem_fault    <= 1'b0;
      end else begin
         wb_valid  <= (state_nx == DONE);
         mem_fault <= accept && fault;
         if (accept) begin
            op_q.addr      <= ex_addr;
            op_q.funct3    <= ex_funct3;
            op_q.store     <= ex_mem_write;
            op_q.reg_write <= ex_reg_write;
            op_q.rd        <= ex_rd;
            wdata_q        <= ex_wdata << {ex_addr[2:0], 3'b000};
            be_q           <= size_mask << ex_addr[2:0];
            if (!is_mem) begin
               wb_data      <= ex_addr;
               wb_reg_write <= ex_reg_write;
               wb_rd        <= ex_rd;
            end else if (fault) begin
               wb_reg_write <= 1'b0;
               wb_rd        <= ex_rd;
            end
         end
         if (state == REQ && dmem_gnt && op_q.store) begin
            wb_reg_write <= 1'b0;
            wb_rd        <= op_q.rd;
         end
         if (state == WAIT && dmem_rvalid) begin
            wb_data      <= ld_val;
            wb_reg_write <= op_q.reg_write;
            wb_rd        <= op_q.rd;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases from the access rules plus
// randomized ops, checked against a byte-level reference model.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset;
   logic        ex_valid, ex_ready;
   logic [63:0] ex_addr, ex_wdata;
   logic [2:0]  ex_funct3;
   logic        ex_mem_read, ex_mem_write, ex_reg_write;
   logic [4:0]  ex_rd;
   logic        dmem_req, dmem_we;
   logic [63:0] dmem_addr, dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_gnt, dmem_rvalid;
   logic [63:0] dmem_rdata;
   logic        wb_valid, wb_reg_write;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        mem_fault;

   int n_chk = 0;
   int n_err = 0;

   load_store_unit dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .ex_funct3(ex_funct3), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
      .mem_fault(mem_fault)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int n = 0;
      while (!ex_ready && n < 20) begin
         tick();
         n++;
      end
      chk("ready_wait", ex_ready, 1'b1);
   endtask

   // Issue one op, play the bus side with the given grant/response delays,
   // and check every cycle against the model.
   task automatic run_op(input bit rd_en, input bit wr_en, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input bit rw, input logic [4:0] rd, input int gd, input int rdl,
                         input logic [63:0] rdata, output logic [63:0] got);
      bit          is_mem, flt;
      int          sz, off;
      logic [63:0] exp_v, exp_wd;
      logic [7:0]  exp_be;
      is_mem = rd_en || wr_en;
      sz     = 1 << f3[1:0];
      off    = int'(addr[2:0]);
      flt    = is_mem && ((rd_en && wr_en) || (rd_en && f3 == 3'b111) ||
                          (wr_en && f3[2]) || ((off % sz) != 0));
      exp_be = '0;
      exp_v  = '0;
      for (int i = 0; i < sz; i++) begin
         if (off + i < 8) begin
            exp_be[off+i] = 1'b1;
            exp_v[8*i +: 8] = rdata[8*(off+i) +: 8];
         end
      end
      if (!f3[2] && sz < 8 && exp_v[8*sz-1])
         for (int j = 8*sz; j < 64; j++) exp_v[j] = 1'b1;
      exp_wd = wdata << (8*off);

      wait_ready();
      ex_addr = addr; ex_wdata = wdata; ex_funct3 = f3;
      ex_mem_read = rd_en; ex_mem_write = wr_en; ex_reg_write = rw; ex_rd = rd;
      ex_valid = 1'b1;
      tick();
      ex_valid = 1'b0;
      chk("busy", ex_ready, 1'b0);
      if (!is_mem || flt) begin
         chk("no_req", dmem_req, 1'b0);
         chk("wb_valid_n1", wb_valid, 1'b1);
         chk("fault", mem_fault, flt);
         chk("wb_rw", wb_reg_write, is_mem ? 1'b0 : rw);
         chk("wb_rd", wb_rd, rd);
         if (!is_mem) chk("wb_data_alu", wb_data, addr);
      end else begin
         for (int g = 0; g <= gd; g++) begin
            chk("req", dmem_req, 1'b1);
            chk("we", dmem_we, wr_en);
            chk("addr", dmem_addr, {addr[63:3], 3'b000});
            chk("be", dmem_be, exp_be);
            if (wr_en) chk("wdata", dmem_wdata, exp_wd);
            chk("ready_req", ex_ready, 1'b0);
            dmem_gnt    = (g == gd);
            dmem_rvalid = (g < gd) ? 1'($urandom % 2) : 1'b0;
            dmem_rdata  = {$urandom, $urandom};
            tick();
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
         end
         if (wr_en) begin
            chk("wb_valid_st", wb_valid, 1'b1);
            chk("fault_st", mem_fault, 1'b0);
            chk("wb_rw_st", wb_reg_write, 1'b0);
            chk("wb_rd_st", wb_rd, rd);
         end else begin
            for (int r = 0; r <= rdl; r++) begin
               chk("wb_early", wb_valid, 1'b0);
               chk("req_wait", dmem_req, 1'b0);
               dmem_rvalid = (r == rdl);
               dmem_rdata  = (r == rdl) ? rdata : {$urandom, $urandom};
               dmem_gnt    = (r < rdl) ? 1'($urandom % 2) : 1'b0;
               tick();
               dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
            end
            chk("wb_valid_ld", wb_valid, 1'b1);
            chk("wb_data_ld", wb_data, exp_v);
            chk("wb_rw_ld", wb_reg_write, rw);
            chk("wb_rd_ld", wb_rd, rd);
            chk("fault_ld", mem_fault, 1'b0);
         end
      end
      got = wb_data;
      tick();
      chk("wb_pulse_end", wb_valid, 1'b0);
      chk("fault_end", mem_fault, 1'b0);
      chk("ready_back", ex_ready, 1'b1);
      if (!is_mem) chk("wb_hold_alu", wb_data, addr);
      else if (rd_en && !flt) chk("wb_hold_ld", wb_data, exp_v);
   endtask

   initial begin
      logic [63:0] got, a, w, rdat;
      logic [2:0]  f3;
      int          kind, sz;
      reset = 1'b0; ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_funct3 = '0;
      ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b0; ex_rd = '0;
      dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
      tick(); tick();
      chk("rst_ready", ex_ready, 1'b0);
      chk("rst_req", dmem_req, 1'b0);
      chk("rst_wbv", wb_valid, 1'b0);
      chk("rst_fault", mem_fault, 1'b0);
      chk("rst_wbdata", wb_data, 64'h0);
      chk("rst_be", dmem_be, 8'h0);
      reset = 1'b1;
      #1;
      chk("rel_ready", ex_ready, 1'b1);

      // Directed cases.
      run_op(1, 0, 3'b011, 64'h100, 64'h0, 1, 5'd5, 0, 0, 64'h1234567890ABCDEF, got);
      chk("ld_const", got, 64'h1234567890ABCDEF);
      run_op(1, 0, 3'b000, 64'h103, 64'h0, 1, 5'd6, 1, 2, 64'h0000_0000_8000_0000, got);
      chk("lb_const", got, 64'hFFFF_FFFF_FFFF_FF80);
      run_op(1, 0, 3'b100, 64'h103, 64'h0, 1, 5'd7, 0, 1, 64'h0000_0000_8000_0000, got);
      chk("lbu_const", got, 64'h80);
      run_op(1, 0, 3'b010, 64'h104, 64'h0, 1, 5'd8, 0, 0, 64'h8000_0001_0000_0000, got);
      chk("lw_const", got, 64'hFFFF_FFFF_8000_0001);
      run_op(0, 1, 3'b011, 64'h200, 64'hB, 0, 5'd0, 0, 0, 64'h0, got);
      run_op(0, 1, 3'b000, 64'h205, 64'hAB, 0, 5'd0, 0, 0, 64'h0, got);
      run_op(0, 1, 3'b010, 64'h208, 64'hDEADBEEF, 0, 5'd0, 3, 0, 64'h0, got);
      run_op(1, 0, 3'b010, 64'h102, 64'h0, 1, 5'd9, 0, 0, 64'h0, got);
      run_op(0, 1, 3'b011, 64'h204, 64'h1, 1, 5'd9, 0, 0, 64'h0, got);
      run_op(1, 0, 3'b111, 64'h100, 64'h0, 1, 5'd9, 0, 0, 64'h0, got);
      run_op(1, 1, 3'b000, 64'h100, 64'h0, 1, 5'd9, 0, 0, 64'h0, got);
      run_op(0, 0, 3'b000, 64'hB, 64'h0, 1, 5'd10, 0, 0, 64'h0, got);
      chk("alu_const", got, 64'hB);
      run_op(1, 0, 3'b011, 64'h108, 64'h0, 1, 5'd0, 0, 0, 64'h55, got);
      chk("x0_rd", wb_rd, 5'd0);

      // Reset while waiting for load data, then a stray response.
      wait_ready();
      ex_addr = 64'h300; ex_funct3 = 3'b011; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
      ex_reg_write = 1'b1; ex_rd = 5'd3; ex_valid = 1'b1;
      tick();
      ex_valid = 1'b0; dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      chk("in_wait", dmem_req, 1'b0);
      reset = 1'b0;
      #1;
      chk("mid_rst_req", dmem_req, 1'b0);
      chk("mid_rst_wbv", wb_valid, 1'b0);
      chk("mid_rst_ready", ex_ready, 1'b0);
      tick(); tick();
      reset = 1'b1;
      #1;
      chk("post_rst_ready", ex_ready, 1'b1);
      dmem_rvalid = 1'b1; dmem_rdata = 64'hFFFF_0000_FFFF_0000;
      tick();
      dmem_rvalid = 1'b0;
      chk("stray_wbv", wb_valid, 1'b0);
      chk("stray_req", dmem_req, 1'b0);
      tick();
      chk("stray_wbv2", wb_valid, 1'b0);
      run_op(1, 0, 3'b001, 64'h302, 64'h0, 1, 5'd4, 1, 1, 64'h0000_0000_9876_0000, got);
      chk("post_rst_lh", got, 64'hFFFF_FFFF_FFFF_9876);

      // Randomized ops.
      for (int n = 0; n < 250; n++) begin
         kind = int'($urandom % 8);
         f3   = 3'($urandom % 8);
         sz   = 1 << f3[1:0];
         a    = {$urandom, $urandom};
         if ($urandom % 4 != 0) a = a & ~64'(sz - 1);
         w    = {$urandom, $urandom};
         rdat = {$urandom, $urandom};
         run_op(kind < 3 || kind == 7, (kind >= 3 && kind < 6) || kind == 7, f3, a, w,
                1'($urandom % 2), 5'($urandom), int'($urandom % 4), int'($urandom % 4),
                rdat, got);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
